// File: rtl/uart_rx_frame_if.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_if
// Parallel-side bundle of the UART receiver: the received byte with its
// valid/ready handshake plus the status and error strobes.
//   rx_data      : last received byte (receiver -> consumer)
//   rx_valid     : rx_data holds an unconsumed byte (receiver -> consumer)
//   rx_ready     : consumer accepts rx_data while rx_valid=1 (consumer -> receiver)
//   rx_busy      : a frame is being received (receiver -> consumer)
//   rx_frame_err : one-cycle pulse, stop bit sampled low (receiver -> consumer)
//   rx_overrun   : one-cycle pulse, good frame dropped because the previous
//                  byte was never taken (receiver -> consumer)
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_busy;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
// 8N1 UART receiver clocked at OVERSAMPLE x baud. The serial line is passed
// through a 2-flop synchronizer, each bit is decided by a 3-sample majority
// vote around mid-bit, and the byte is handed out over a valid/ready
// handshake. Bad stop bits and dropped bytes are flagged with 1-cycle pulses.
// Ports:
//   uart_clk_tx  : oversample clock, all logic on the rising edge
//   RST_n        : synchronous active-low reset
//   uart_rx_data : asynchronous serial input, idles high
//   rx_if        : parallel handshake/status bundle (master side)
// ----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic             uart_clk_tx,
  input  logic             RST_n,
  input  logic             uart_rx_data,
  uart_rx_frame_if.master  rx_if
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OS_W-1:0]  OS_HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_HALF    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_HALF_P1 = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 vote;

  // The third vote sample is the live sync2 value at os_cnt = OVERSAMPLE/2+1,
  // so the vote is only meaningful on that cycle.
  assign vote = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);

  always_comb begin
    state_d     = state_q;
    sync1_d     = uart_rx_data;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (os_cnt_q == OS_HALF_M1) samp0_d = sync2_q;
    if (os_cnt_q == OS_HALF)    samp1_d = sync2_q;

    // Handshake is resolved before delivery, so a byte arriving on the same
    // cycle the consumer takes the old one loads cleanly instead of overrunning.
    if (rx_valid_q && rx_if.rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        // Edge detect rather than level so a line stuck low never retriggers.
        if (!sync2_q && prev_q) state_d = START;
      end
      START: begin
        os_cnt_d = os_cnt_q + 1'b1;
        if (os_cnt_q == OS_HALF_P1 && vote) begin
          state_d  = IDLE;
          os_cnt_d = '0;
        end else if (os_cnt_q == OS_LAST) begin
          state_d   = DATA;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        os_cnt_d = os_cnt_q + 1'b1;
        if (os_cnt_q == OS_HALF_P1) shift_reg_d = {vote, shift_reg_q[DATA_BITS-1:1]};
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        os_cnt_d = os_cnt_q + 1'b1;
        // Leaving at mid stop bit gives half a bit of slack for the next start edge.
        if (os_cnt_q == OS_HALF_P1) begin
          state_d  = IDLE;
          os_cnt_d = '0;
          if (!vote) begin
            frame_err_d = 1'b1;
          end else if (rx_valid_d) begin
            overrun_d = 1'b1;
          end else begin
            rx_data_d  = shift_reg_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        os_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge uart_clk_tx) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data      = rx_data_q;
  assign rx_if.rx_valid     = rx_valid_q;
  assign rx_if.rx_busy      = (state_q != IDLE);
  assign rx_if.rx_frame_err = frame_err_q;
  assign rx_if.rx_overrun   = overrun_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receiver that deserializes one asynchronous 8N1 frame at a time from a single serial line into a parallel byte with a valid/ready handshake. It is the receive-side counterpart of the board's UART transmitter and runs on the same baud-generator clock, configured at OVERSAMPLE times the bit rate. Frame errors and overruns are flagged. Input glitches are suppressed by a 2-flop synchronizer and a 3-sample majority vote at mid-bit.

## Interface
- OVERSAMPLE, 16: clock cycles per bit. Must be even and ≥ 8.
- DATA_BITS, 8: data bits per frame, sent LSB first.
- uart_clk_tx  in  1: oversample clock (OVERSAMPLE × baud). All logic is on its rising edge.
- RST_n  in  1: reset, synchronous, active-low.
- uart_rx_data  in  1: asynchronous serial line; idles high.
- rx_ready  in  1: consumer accepts rx_data while rx_valid=1.
- rx_data  out  DATA_BITS: last received byte.
- rx_valid  out  1: rx_data holds an unconsumed byte.
- rx_busy  out  1: a frame is in progress (state ≠ IDLE).
- rx_frame_err  out  1: one-cycle pulse when a stop bit is sampled low.
- rx_overrun  out  1: one-cycle pulse when a good frame completes while rx_valid=1.

## Operation
- Synchronizer: two flops, sync1 → sync2, both reset to 1. A third flop, prev, holds the previous sync2 value and resets to 1.
- os_cnt counts 0..OVERSAMPLE-1 within each bit period. bit_cnt counts 0..DATA_BITS-1.
- Voting: within each bit period, sync2 is sampled at os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three samples, resolved at os_cnt = OVERSAMPLE/2+1.
- State machine:
  - IDLE: when sync2=0 and prev=1 (falling edge), go to START with os_cnt=0. A line held low does not re-trigger.
  - START: if the vote is 1, it is a false start: go to IDLE, with no flags. If the vote is 0, continue counting. At os_cnt=OVERSAMPLE-1, go to DATA with os_cnt=0 and bit_cnt=0.
  - DATA: at vote resolution, shift the vote into shift_reg[DATA_BITS-1] and shift right, so bits land LSB first. At os_cnt=OVERSAMPLE-1: if bit_cnt=DATA_BITS-1, go to STOP; otherwise increment bit_cnt.
  - STOP: at vote resolution, go to IDLE immediately without waiting for the end of the stop bit. This allows back-to-back frames.
    - Vote 1 and rx_valid=0: rx_data ← shift_reg, rx_valid ← 1.
    - Vote 1 and rx_valid=1: rx_data is unchanged, the new byte is dropped, and rx_overrun pulses.
    - Vote 0: rx_frame_err pulses. The byte is discarded and rx_data/rx_valid are unchanged.
- Handshake: rx_valid clears on the cycle after rx_valid & rx_ready. If rx_ready is high on the same cycle a new byte is delivered, the new byte loads and rx_valid stays 1. That delivery is not an overrun, because the handshake completes first.
- rx_data changes only on delivery.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0.
  - State IDLE, os_cnt=0, bit_cnt=0, shift_reg=0.
  - sync1, sync2 and prev = 1.
- Reset mid-frame aborts the frame on the next edge: no flags, pending rx_valid is cleared.
- Edge latency: a line falling edge reaches sync2 after 2 cycles. The START transition follows 1 cycle after that.
- rx_busy is 1 from the START entry cycle through the STOP vote cycle, inclusive.
- Delivery latency: rx_valid rises 1 cycle after the STOP vote. This is about 9.5 bit periods plus 3–4 cycles after the start-bit falling edge.
- rx_frame_err and rx_overrun are high for exactly one cycle and are never high together.
- Baud tolerance: the receiver must decode correctly with a transmitter bit period within ±3% of nominal.

## Test plan
- Basic frame: OVERSAMPLE=16, send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) with rx_ready=1 → rx_data=0xA5, rx_valid high for 1 cycle, rx_busy high for roughly 152 cycles, no error flags.
- Back-to-back frames: 0x00 then 0xFF, with only one stop bit between them and rx_ready tied high → two deliveries in order: 0x00, then 0xFF.
- False start and glitch rejection:
  - Line low for 4 cycles, then high → no START completion, no flags, rx_busy drops once the START vote resolves.
  - Frame 0x3C with a 1-cycle inverted glitch on bit 2 at mid-bit → still 0x3C.
- Frame error: 0x3C sent with a low stop bit → rx_frame_err pulses for 1 cycle, rx_valid stays 0. The line then held low for 40 cycles produces no new frame; the next clean 0x11 is received correctly.
- Overrun: rx_ready=0, send 0x12 then 0x34 → rx_data stays 0x12, rx_valid stays 1, rx_overrun pulses once at the second STOP vote. Raising rx_ready for 1 cycle then clears rx_valid.
- Reset mid-frame: assert RST_n=0 for 1 cycle during DATA bit 4 of 0x5A → all outputs return to reset values and no byte is delivered. A subsequent 0x5A is received correctly.
